// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bubble encoding and inter-stage payload layouts.
package pipe_pkg;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    localparam int IFID_W = 64;   // {pc, instr}
    localparam int IDEX_W = 160;  // {pc, rs_val, rt_val, imm, ctrl}

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+data holding register with clear (dominant) and load.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = IFID_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // NOTE: state updates use <= so every slot samples pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= BUBBLE_VAL;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= BUBBLE_VAL;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, optional skid slot and flush.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = IFID_W,
    parameter bit                SKID_EN    = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(MIPS_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              adv;
    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_d;

    assign in_fire   = in_valid && in_ready;
    assign adv       = !main_valid || out_ready;   // main empty or being consumed
    assign main_d    = skid_valid ? skid_data : in_data;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    // NOTE: defaults first so no path through this block leaves a stored value (no latch).
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
        end else if (adv) begin
            if (skid_valid || in_fire) main_load  = 1'b1;
            else                       main_clear = 1'b1;
        end
    end

    pipe_skid_slot #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE_VAL)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .data  (main_data)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic skid_load;
            logic skid_clear;

            // Registered ready: depends only on skid occupancy, never on out_ready.
            assign in_ready   = !skid_valid;
            assign skid_load  = !flush && in_fire && !(adv && !skid_valid);
            assign skid_clear = flush || (adv && skid_valid && !skid_load);

            pipe_skid_slot #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE_VAL)) u_skid (
                .clk   (clk),
                .rst   (rst),
                .load  (skid_load),
                .clear (skid_clear),
                .d     (in_data),
                .valid (skid_valid),
                .data  (skid_data)
            );
        end else begin : g_noskid
            assign in_ready   = !main_valid || out_ready;
            assign skid_valid = 1'b0;
            assign skid_data  = BUBBLE_VAL;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: skid instance (a_*) and no-skid instance (b_*).
`timescale 1ns/1ps
module tb_pipe_stage_buf;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        b_flush;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_in_data, b_out_data;

    logic [63:0] a_q[$];
    logic [63:0] b_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;

    pipe_stage_buf #(.DATA_W(64), .SKID_EN(1'b1), .BUBBLE_VAL(64'h0)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
    );

    pipe_stage_buf #(.DATA_W(64), .SKID_EN(1'b0), .BUBBLE_VAL(64'h0)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors sample on the falling edge: a valid&ready seen here fires at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_out_valid && a_out_ready) begin
                if (a_q.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL a_unexpected: got %h expected no output", a_out_data);
                end else begin
                    check("a_order", a_out_data, a_q.pop_front());
                end
            end
            if (!a_out_valid) check("a_bubble", a_out_data, 64'h0);
            if (b_out_valid && b_out_ready) begin
                if (b_q.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL b_unexpected: got %h expected no output", b_out_data);
                end else begin
                    check("b_order", b_out_data, b_q.pop_front());
                end
            end
            if (!b_out_valid) check("b_bubble", b_out_data, 64'h0);
        end
    end

    task automatic drain_a(input string name);
        for (int i = 0; i < 40 && a_q.size() != 0; i++) tick();
        check(name, 64'(a_q.size()), 64'd0);
    endtask

    task automatic drain_b(input string name);
        for (int i = 0; i < 40 && b_q.size() != 0; i++) tick();
        check(name, 64'(b_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        fire;
        logic [63:0] next_val;

        rst = 1'b1; flush = 1'b0; b_flush = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_out_data",  a_out_data,       64'h0);
        check("rst_a_in_ready",  64'(a_in_ready),  64'd1);
        check("rst_b_in_ready",  64'(b_in_ready),  64'd1);
        rst = 1'b0;
        tick();

        // 1: asynchronous reset while holding 0xA (main) and 0xB (skid)
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 64'hA;
        tick();
        a_in_data = 64'hB;
        tick();
        a_in_valid = 1'b0;
        check("s1_held_data", a_out_data, 64'hA);
        check("s1_full_ready", 64'(a_in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("s1_async_out_valid", 64'(a_out_valid), 64'd0);
        check("s1_async_out_data",  a_out_data,       64'h0);
        check("s1_async_in_ready",  64'(a_in_ready),  64'd1);
        tick();
        rst = 1'b0;
        a_out_ready = 1'b1;
        tick();
        tick();
        check("s1_after_rst_valid", 64'(a_out_valid), 64'd0);

        // 2: back-to-back streaming with out_ready held high
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) a_q.push_back(64'(i));
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1; a_in_data = 64'(i);
            check("s2_in_ready", 64'(a_in_ready), 64'd1);
            tick();
            check("s2_out_valid", 64'(a_out_valid), 64'd1);
            check("s2_latency",   a_out_data,       64'(i));
        end
        a_in_valid = 1'b0;
        drain_a("s2_drain");

        // 3: stall fills main and skid, then release drains without a gap
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 64'h10;
        tick();
        a_in_data = 64'h11;
        check("s3_ready_before", 64'(a_in_ready), 64'd1);
        tick();
        a_in_data = 64'h12;
        check("s3_ready_drop", 64'(a_in_ready), 64'd0);
        tick();
        check("s3_ready_held", 64'(a_in_ready), 64'd0);
        check("s3_out_stable", a_out_data, 64'h10);
        a_q.push_back(64'h10); a_q.push_back(64'h11); a_q.push_back(64'h12);
        a_out_ready = 1'b1;
        tick();
        check("s3_second", a_out_data, 64'h11);
        tick();
        a_in_valid = 1'b0;
        check("s3_third", a_out_data, 64'h12);
        tick();
        check("s3_empty", 64'(a_out_valid), 64'd0);
        drain_a("s3_drain");

        // 4: flush while full with a pending input
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 64'h20;
        tick();
        a_in_data = 64'h21;
        tick();
        a_in_data = 64'h22;
        flush = 1'b1;
        tick();
        flush = 1'b0; a_in_valid = 1'b0;
        check("s4_out_valid", 64'(a_out_valid), 64'd0);
        check("s4_out_data",  a_out_data,       64'h0);
        check("s4_in_ready",  64'(a_in_ready),  64'd1);
        a_out_ready = 1'b1;
        tick();
        tick();
        check("s4_skid_gone", 64'(a_out_valid), 64'd0);
        // flush with an accepted input on an empty stage
        a_in_valid = 1'b1; a_in_data = 64'h23;
        flush = 1'b1;
        tick();
        flush = 1'b0; a_in_valid = 1'b0;
        check("s4_fire_discard", 64'(a_out_valid), 64'd0);
        tick();
        check("s4_fire_discard2", 64'(a_out_valid), 64'd0);

        // 5: drain a full stage while the next entry is offered
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 64'h30;
        tick();
        a_in_data = 64'h31;
        tick();
        a_in_data = 64'h32;
        a_q.push_back(64'h30); a_q.push_back(64'h31); a_q.push_back(64'h32);
        check("s5_full_ready", 64'(a_in_ready), 64'd0);
        a_out_ready = 1'b1;
        tick();
        check("s5_second", a_out_data, 64'h31);
        tick();
        a_in_valid = 1'b0;
        check("s5_third", a_out_data, 64'h32);
        drain_a("s5_drain");
        a_out_ready = 1'b0;

        // 6: single-register variant, combinational ready
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 64'h40;
        b_q.push_back(64'h40);
        tick();
        b_in_valid = 1'b0;
        check("s6_ready_low", 64'(b_in_ready), 64'd0);
        b_out_ready = 1'b1;
        #1;
        check("s6_ready_comb", 64'(b_in_ready), 64'd1);
        tick();
        b_out_ready = 1'b0;
        #1;
        check("s6_ready_empty", 64'(b_in_ready), 64'd1);
        tick();

        next_val = 64'h100;
        for (int c = 0; c < 200; c++) begin
            if (!b_in_valid) begin
                b_in_valid = 1'($urandom_range(0, 1));
                b_in_data  = next_val;
            end
            b_out_ready = 1'($urandom_range(0, 1));
            #3;
            fire = b_in_valid && b_in_ready;
            if (fire) begin
                b_q.push_back(b_in_data);
                next_val = next_val + 64'd1;
            end
            tick();
            if (fire) b_in_valid = 1'b0;
        end
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        drain_b("s6_drain");
        tick();
        check("s6_idle", 64'(b_out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
